wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 144 ++++++++++++++
 tb/tb_wb_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Pipeline writeback stage. Selects the writeback data source
//             (ALU result, memory word, link address or immediate), registers
//             it with its destination index, write enable and valid, and keeps
//             a 32-bit retired-instruction counter.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN        datapath width, must be >= 32
//    PC_INC      link-address increment added to pc
//  Ports
//    clk          in   1     rising-edge clock
//    rst          in   1     synchronous active-high reset
//    stall        in   1     hold all registered outputs
//    flush        in   1     kill the entry being captured
//    in_valid     in   1     input bundle is a live instruction
//    reg_write    in   1     instruction writes rd
//    rd           in   5     destination register index
//    mem_to_reg   in   2     0 alu_result, 1 mem_data, 2 pc+PC_INC, 3 imm
//    funct3       in   3     load type (LOAD_EXT_EN builds only)
//    alu_result   in   XLEN  ALU result, [1:0] = load byte offset
//    mem_data     in   XLEN  raw memory read word
//    pc           in   XLEN  instruction address
//    imm          in   XLEN  immediate
//    out          out  XLEN  registered writeback data
//    out_rd       out  5     registered destination index
//    out_we       out  1     registered register-file write enable
//    out_valid    out  1     registered valid
//    retire_count out  32    retired-instruction counter
//  Build option
//    LOAD_EXT_EN  when defined, memory data is byte/half extracted and
//                 sign/zero extended according to funct3
// ============================================================================
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            reg_write,
    input  logic [4:0]      rd,
    input  logic [1:0]      mem_to_reg,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] out,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_valid,
    output logic [31:0]     retire_count
);

    localparam logic [1:0] c_SEL_ALU = 2'd0;
    localparam logic [1:0] c_SEL_MEM = 2'd1;
    localparam logic [1:0] c_SEL_PC  = 2'd2;

    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_sel;

    logic [XLEN-1:0] r_out;
    logic [4:0]      r_out_rd;
    logic            r_out_we;
    logic            r_out_valid;
    logic [31:0]     r_retire_count;

`ifdef LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane picked by the address offset; halfwords ignore offset bit 0.
    always_comb begin
        w_byte = mem_data[7:0];
        case (alu_result[1:0])
            2'd1:    w_byte = mem_data[15:8];
            2'd2:    w_byte = mem_data[23:16];
            2'd3:    w_byte = mem_data[31:24];
            default: w_byte = mem_data[7:0];
        endcase
        w_half = alu_result[1] ? mem_data[31:16] : mem_data[15:0];

        // Size casts of signed values sign-extend, of unsigned values zero-extend.
        case (funct3)
            3'b000:  w_load = XLEN'($signed(w_byte));
            3'b001:  w_load = XLEN'($signed(w_half));
            3'b100:  w_load = XLEN'(w_byte);
            3'b101:  w_load = XLEN'(w_half);
            default: w_load = XLEN'($signed(mem_data[31:0]));
        endcase
    end
`else
    // funct3 has no role when loads are passed through untouched.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^funct3;
    assign w_load          = mem_data;
`endif

    always_comb begin
        case (mem_to_reg)
            c_SEL_ALU: w_sel = alu_result;
            c_SEL_MEM: w_sel = w_load;
            c_SEL_PC:  w_sel = pc + XLEN'(PC_INC);
            default:   w_sel = imm;
        endcase
    end

    // Priority: reset, then flush (even when stalled), then stall hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_out_rd       <= '0;
            r_out_we       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_retire_count <= '0;
        end else if (flush) begin
            r_out       <= '0;
            r_out_rd    <= '0;
            r_out_we    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_out       <= w_sel;
            r_out_rd    <= rd;
            r_out_we    <= in_valid & reg_write & (rd != 5'd0);
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign out          = r_out;
    assign out_rd       = r_out_rd;
    assign out_we       = r_out_we;
    assign out_valid    = r_out_valid;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Self-checking bench for wb_stage. A behavioural model predicts
//             the registered state for each cycle and queues it; after the
//             clock edge the prediction is popped and compared with the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    typedef struct packed {
        logic [31:0] out;
        logic [4:0]  rd;
        logic        we;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  mem_to_reg;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] out;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_valid;
    logic [31:0] retire_count;

    exp_t m;          // model of the registered state
    exp_t sb[$];      // scoreboard of predictions
    exp_t e;
    exp_t g;
    int   n_chk  = 0;
    int   n_pass = 0;

    wb_stage #(.XLEN(32), .PC_INC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .reg_write    (reg_write),
        .rd           (rd),
        .mem_to_reg   (mem_to_reg),
        .funct3       (funct3),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .pc           (pc),
        .imm          (imm),
        .out          (out),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_valid    (out_valid),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] load_model();
        logic [31:0] b;
        logic [31:0] h;
`ifdef LOAD_EXT_EN
        b = (mem_data >> (8 * alu_result[1:0])) & 32'hFF;
        h = (mem_data >> (16 * alu_result[1])) & 32'hFFFF;
        case (funct3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return mem_data;
        endcase
`else
        b = 32'd0;
        h = 32'd0;
        return mem_data | b | h;
`endif
    endfunction

    function automatic logic [31:0] sel_model();
        case (mem_to_reg)
            2'd0:    return alu_result;
            2'd1:    return load_model();
            2'd2:    return pc + 32'd4;
            default: return imm;
        endcase
    endfunction

    // Advance the model with the current inputs and queue its prediction.
    function automatic void predict();
        exp_t n;
        n = m;
        if (rst) begin
            n = '0;
        end else if (flush) begin
            n.out = '0; n.rd = '0; n.we = 1'b0; n.valid = 1'b0;
        end else if (!stall) begin
            n.out   = sel_model();
            n.rd    = rd;
            n.we    = in_valid && reg_write && (rd != 5'd0);
            n.valid = in_valid;
            if (in_valid) n.cnt = m.cnt + 32'd1;
        end
        m = n;
        sb.push_back(n);
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.out = out; s.rd = out_rd; s.we = out_we; s.valid = out_valid; s.cnt = retire_count;
        return s;
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("out=%h rd=%0d we=%b valid=%b count=%h", x.out, x.rd, x.we, x.valid, x.cnt);
    endfunction

    task automatic cycle();
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic w, input logic [4:0] d,
                          input logic [1:0] s, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] md,
                          input logic [31:0] p, input logic [31:0] i);
        in_valid = v; reg_write = w; rd = d; mem_to_reg = s; funct3 = f;
        alu_result = a; mem_data = md; pc = p; imm = i;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 5'd7, 2'd0, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        cycle();
        e = sb.pop_front(); g = sample();
        n_chk++;
        if (g !== e) $display("FAIL reset_sb: got %s, required %s", fmt(g), fmt(e));
        else n_pass++;
        n_chk++;
        if ({out, out_rd, out_we, out_valid, retire_count} !== 71'd0)
            $display("FAIL reset_zero: got %s, required all zero", fmt(g));
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_select();
        logic [31:0] lit [4];
        lit[0] = 32'h11; lit[1] = 32'h22; lit[2] = 32'h104; lit[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 5'd5, 2'(i), 3'b010, 32'h11, 32'h22, 32'h100, 32'h44);
            cycle();
            e = sb.pop_front(); g = sample();
            n_chk++;
            if (g !== e) $display("FAIL select_sb[%0d]: got %s, required %s", i, fmt(g), fmt(e));
            else n_pass++;
            n_chk++;
            if (out !== lit[i] || out_we !== 1'b1)
                $display("FAIL select_out[%0d]: got out=%h we=%b, required out=%h we=1", i, out, out_we, lit[i]);
            else n_pass++;
        end
        n_chk++;
        if (retire_count !== 32'd4) $display("FAIL select_count: got %0d, required 4", retire_count);
        else n_pass++;
    endtask

    task automatic test_no_write();
        logic [4:0] rds [2];
        logic       wes [2];
        rds[0] = 5'd0; wes[0] = 1'b1;
        rds[1] = 5'd3; wes[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, wes[i], rds[i], 2'd3, 3'b000, 32'h0, 32'h0, 32'h0, 32'h99 + 32'(i));
            cycle();
            e = sb.pop_front(); g = sample();
            n_chk++;
            if (g !== e) $display("FAIL no_write_sb[%0d]: got %s, required %s", i, fmt(g), fmt(e));
            else n_pass++;
            n_chk++;
            if (out_valid !== 1'b1 || out_we !== 1'b0 || retire_count !== 32'(5 + i))
                $display("FAIL no_write[%0d]: got valid=%b we=%b count=%0d, required valid=1 we=0 count=%0d",
                         i, out_valid, out_we, retire_count, 5 + i);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_cnt;
        set_in(1'b1, 1'b1, 5'd9, 2'd0, 3'b010, 32'hABCD, 32'h0, 32'h0, 32'h0);
        cycle();
        e = sb.pop_front(); g = sample();
        n_chk++;
        if (g !== e) $display("FAIL stall_prep: got %s, required %s", fmt(g), fmt(e));
        else n_pass++;
        held_cnt = m.cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 5'(20 + i), 2'(i), 3'b000, 32'(i * 7), 32'hFFFF_0000, 32'h200, 32'h55);
            cycle();
            e = sb.pop_front(); g = sample();
            n_chk++;
            if (g !== e) $display("FAIL stall_sb[%0d]: got %s, required %s", i, fmt(g), fmt(e));
            else n_pass++;
            n_chk++;
            if (out !== 32'hABCD || out_rd !== 5'd9 || retire_count !== held_cnt)
                $display("FAIL stall_hold[%0d]: got out=%h rd=%0d count=%h, required out=0000abcd rd=9 count=%h",
                         i, out, out_rd, retire_count, held_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] held_cnt;
        held_cnt = m.cnt;
        stall = 1'b1; flush = 1'b1;
        set_in(1'b1, 1'b1, 5'd4, 2'd3, 3'b000, 32'h1, 32'h2, 32'h3, 32'h4);
        cycle();
        e = sb.pop_front(); g = sample();
        n_chk++;
        if (g !== e) $display("FAIL flush_sb: got %s, required %s", fmt(g), fmt(e));
        else n_pass++;
        n_chk++;
        if (out !== 32'd0 || out_rd !== 5'd0 || out_we !== 1'b0 || out_valid !== 1'b0 || retire_count !== held_cnt)
            $display("FAIL flush_clear: got %s, required zero outputs count=%h", fmt(g), held_cnt);
        else n_pass++;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_wrap();
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m.cnt = 32'hFFFF_FFFF;
        set_in(1'b1, 1'b1, 5'd1, 2'd0, 3'b010, 32'h77, 32'h0, 32'h0, 32'h0);
        cycle();
        e = sb.pop_front(); g = sample();
        n_chk++;
        if (g !== e) $display("FAIL wrap_sb: got %s, required %s", fmt(g), fmt(e));
        else n_pass++;
        n_chk++;
        if (retire_count !== 32'd0) $display("FAIL wrap_count: got %h, required 00000000", retire_count);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        set_in(1'b1, 1'b1, 5'd2, 2'd0, 3'b010, 32'h5, 32'h0, 32'h0, 32'h0);
        cycle();
        void'(sb.pop_front());
        rst = 1'b1; flush = 1'b0; stall = 1'b1;
        cycle();
        e = sb.pop_front(); g = sample();
        n_chk++;
        if (g !== e) $display("FAIL rst_prio_sb: got %s, required %s", fmt(g), fmt(e));
        else n_pass++;
        n_chk++;
        if ({out, out_rd, out_we, out_valid, retire_count} !== 71'd0)
            $display("FAIL rst_prio_zero: got %s, required all zero", fmt(g));
        else n_pass++;
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [6];
        logic [1:0]  off [6];
        logic [31:0] lit [6];
        f3[0] = 3'b000; off[0] = 2'd0; lit[0] = 32'hFFFF_FF82;
        f3[1] = 3'b100; off[1] = 2'd3; lit[1] = 32'h0000_0080;
        f3[2] = 3'b001; off[2] = 2'd2; lit[2] = 32'hFFFF_80F1;
        f3[3] = 3'b101; off[3] = 2'd3; lit[3] = 32'h0000_80F1;
        f3[4] = 3'b000; off[4] = 2'd1; lit[4] = 32'h0000_007F;
        f3[5] = 3'b011; off[5] = 2'd1; lit[5] = 32'h80F1_7F82;
        for (int i = 0; i < 6; i++) begin
`ifndef LOAD_EXT_EN
            lit[i] = 32'h80F1_7F82;
`endif
            set_in(1'b1, 1'b1, 5'd10, 2'd1, f3[i], {30'h0, off[i]}, 32'h80F1_7F82, 32'h0, 32'h0);
            cycle();
            e = sb.pop_front(); g = sample();
            n_chk++;
            if (g !== e) $display("FAIL load_sb[%0d]: got %s, required %s", i, fmt(g), fmt(e));
            else n_pass++;
            n_chk++;
            if (out !== lit[i]) $display("FAIL load_out[%0d]: got %h, required %h", i, out, lit[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            rst   = ($urandom_range(0, 24) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            set_in(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                   $urandom, $urandom, $urandom, $urandom);
            cycle();
            e = sb.pop_front(); g = sample();
            n_chk++;
            if (g !== e) $display("FAIL b2b[%0d]: got %s, required %s", i, fmt(g), fmt(e));
            else n_pass++;
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        m = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_select();
        test_no_write();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_priority();
        test_loads();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
